// File: rtl/seq_mult_digit_2x3_pkg.sv
// Shared types and digit-width constants for the digit-serial 2x3 multiplier.
//   state_e   : controller states
//   A_DIGIT_W : width of one multiplicand digit fed to the core
//   B_DIGIT_W : width of one multiplier digit fed to the core
//   CORE_PW   : width of one core product (3 * 7 = 21 fits in 5 bits)
package seq_mult_digit_2x3_pkg;

    localparam int unsigned A_DIGIT_W = 2;
    localparam int unsigned B_DIGIT_W = 3;
    localparam int unsigned CORE_PW   = A_DIGIT_W + B_DIGIT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult_digit_2x3_mult_2_3.sv
// Purely combinational 2-bit x 3-bit unsigned multiplier core.
//   a_i      : 2-bit multiplicand digit
//   b_i      : 3-bit multiplier digit
//   prod_c_o : 5-bit product, combinational (no register)
module seq_mult_digit_2x3_mult_2_3
    import seq_mult_digit_2x3_pkg::*;
(
    input  logic [A_DIGIT_W-1:0] a_i,
    input  logic [B_DIGIT_W-1:0] b_i,
    output logic [CORE_PW-1:0]   prod_c_o
);

    logic [CORE_PW-1:0] pp0;
    logic [CORE_PW-1:0] pp1;

    // Two shifted partial products, one per multiplicand bit.
    always_comb begin
        pp0      = a_i[0] ? CORE_PW'(b_i) : '0;
        pp1      = a_i[1] ? (CORE_PW'(b_i) << 1) : '0;
        prod_c_o = pp0 + pp1;
    end

endmodule

// File: rtl/seq_mult_digit_2x3.sv
// Sequential unsigned multiplier: splits A into 2-bit digits and B into
// 3-bit digits, feeds one digit pair per cycle to the 2x3 core and
// accumulates the shifted partial products.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (in_a, in_b)
//   out_valid/out_ready : product handshake (out_p = in_a * in_b)
//   busy              : high while partial products are being accumulated
// Latency: accept in cycle 0 -> out_valid in cycle A_DIGITS*B_DIGITS+1.
module seq_mult_digit_2x3
    import seq_mult_digit_2x3_pkg::*;
#(
    parameter  int unsigned A_DIGITS = 4,
    parameter  int unsigned B_DIGITS = 3,
    localparam int unsigned AW       = A_DIGIT_W * A_DIGITS,
    localparam int unsigned BW       = B_DIGIT_W * B_DIGITS,
    localparam int unsigned PW       = AW + BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_a,
    input  logic [BW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_p,
    output logic          busy
);

    localparam int unsigned IW  = (A_DIGITS > 1) ? $clog2(A_DIGITS) : 1;
    localparam int unsigned JW  = (B_DIGITS > 1) ? $clog2(B_DIGITS) : 1;
    // Largest shift is PW-CORE_PW, so clog2(PW) bits always suffice.
    localparam int unsigned SHW = $clog2(PW);

    localparam logic [IW-1:0] I_LAST = IW'(A_DIGITS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(B_DIGITS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [PW-1:0] out_p_q, out_p_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic [SHW-1:0]       shamt_a;
    logic [SHW-1:0]       shamt_b;
    logic [SHW-1:0]       shamt;
    logic [A_DIGIT_W-1:0] a_dig;
    logic [B_DIGIT_W-1:0] b_dig;
    logic [CORE_PW-1:0]   core_p;
    logic [PW-1:0]        addend;
    logic [PW-1:0]        acc_sum;

    // Digit selection: A digit i sits at bit 2i, B digit j at bit 3j.
    always_comb begin
        shamt_a = SHW'({i_q, 1'b0});
        shamt_b = SHW'(j_q) + SHW'({j_q, 1'b0});
        shamt   = shamt_a + shamt_b;
        a_dig   = A_DIGIT_W'(a_q >> shamt_a);
        b_dig   = B_DIGIT_W'(b_q >> shamt_b);
    end

    seq_mult_digit_2x3_mult_2_3 u_core (
        .a_i      (a_dig),
        .b_i      (b_dig),
        .prod_c_o (core_p)
    );

    // Weighted partial product; the exact product always fits in PW bits.
    always_comb begin
        addend  = PW'(core_p) << shamt;
        acc_sum = acc_q + addend;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        out_p_d = out_p_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                if (j_q == J_LAST) begin
                    j_d = '0;
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        out_p_d = acc_sum;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == CALC);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            out_p_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            out_p_q     <= out_p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = busy_q;

endmodule
